// File: rtl/pkg_dual_port_ram.sv
// pkg_dual_port_ram: one write port, one read port, write-first bypass, zero-fill after reset.
// Define PKG_DUAL_PORT_RAM_OUTREG_EN to add an output register stage, making read latency 2.
module pkg_dual_port_ram #(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned ADDR_WIDTH     = 8,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  init_done,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data
);
   typedef enum logic {CLEAR, READY} state_t;
   localparam state_t RST_STATE = CLEAR_ON_RESET ? CLEAR : READY;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
   logic                  init_done_q;
   logic                  rd_valid_q, rd_valid_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic                  we;
   logic [ADDR_WIDTH-1:0] wa;
   logic [DATA_WIDTH-1:0] wd;

   // Zero-fill owns the write port while clearing; in READY the user port drives it and reads are served.
   always_comb begin
      state_d    = state_q;
      clr_cnt_d  = clr_cnt_q;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      we         = 1'b0;
      wa         = wr_addr;
      wd         = wr_data;
      if (state_q == CLEAR) begin
         we        = 1'b1;
         wa        = clr_cnt_q;
         wd        = '0;
         clr_cnt_d = clr_cnt_q + 1'b1;
         if (clr_cnt_q == '1) state_d = READY;
      end else begin
         we         = wr_req;
         rd_valid_d = rd_req;
         if (rd_req) rd_data_d = (wr_req && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
      end
   end

   // State, clear counter and first read stage; init_done tracks the state being entered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= RST_STATE;
         clr_cnt_q   <= '0;
         init_done_q <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         init_done_q <= (state_d == READY);
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
      end
   end

   // Array write; reset never touches the contents.
   always_ff @(posedge clk) begin
      if (rst_n && we) mem[wa] <= wd;
   end

   assign init_done = init_done_q;

`ifdef PKG_DUAL_PORT_RAM_OUTREG_EN
   logic                  out_valid_q;
   logic [DATA_WIDTH-1:0] out_data_q;

   // Extra output stage; valid and data move together, bypass data included.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= rd_valid_q;
         out_data_q  <= rd_data_q;
      end
   end

   assign rd_valid = out_valid_q;
   assign rd_data  = out_data_q;
`else
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
`endif
endmodule

// File: doc/pkg_dual_port_ram.md
Name: pkg_dual_port_ram

Overview:
- Parametrised successor to the single-port packaged RAM used by the link-table storage.
- Provides one write port and one independent read port, with a registered read and a read-valid flag.
- Same-cycle read/write to the same address returns the new data (write-first).
- A clear state machine zero-fills the whole array after reset and flags completion, so link-table logic needs no software init.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH words.
- CLEAR_ON_RESET, 1, 1 = run the zero-fill after reset; 0 = go straight to READY, contents undefined.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- init_done  output  1  high when the array is usable (READY state).
- wr_req  input  1  write strobe.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- rd_req  input  1  read strobe.
- rd_addr  input  ADDR_WIDTH  read address.
- rd_valid  output  1  rd_data holds a fresh result this cycle.
- rd_data  output  DATA_WIDTH  read result.

Behaviour:
- Reset: sampled at a clk edge with rst_n=0. It forces:
  - init_done=0, rd_valid=0, rd_data=0.
  - clear counter=0.
  - state=CLEAR if CLEAR_ON_RESET=1, else READY.
  - Array contents are not touched by reset itself.
- State CLEAR:
  - Each cycle writes 0 to mem[clr_cnt], then clr_cnt += 1.
  - When clr_cnt == 2**ADDR_WIDTH-1 is written, go to READY next cycle.
  - Clear takes exactly 2**ADDR_WIDTH cycles after reset release.
  - wr_req and rd_req are ignored (no write, rd_valid stays 0).
  - Reset asserted mid-clear restarts the clear from address 0.
- State READY:
  - init_done=1. Stays in READY until the next reset.
- Write (READY): wr_req=1 at edge N stores wr_data into mem[wr_addr] at edge N.
- Read (READY), default build:
  - rd_req=1 at edge N gives rd_valid=1 and rd_data=mem[rd_addr] after edge N.
  - Latency is 1 cycle.
  - rd_req=0 gives rd_valid=0 next cycle; rd_data holds its last value.
- Collision (rd_req, wr_req, rd_addr==wr_addr in the same cycle): rd_data=wr_data (write-first bypass).
- Different-address simultaneous read and write proceed independently, no stall.
- Back-to-back reads every cycle give rd_valid continuously high, with one result per cycle and no bubbles.
- Address wrap: addresses are modulo depth by width, so there is no out-of-range case.
- No backpressure: every accepted request completes.

Optional Feature:
- Macro: PKG_DUAL_PORT_RAM_OUTREG_EN.
- Defined: adds an output register stage.
  - Read latency becomes 2 cycles; rd_valid and rd_data are delayed together.
  - Reset clears both stages to 0.
  - Collision bypass data flows through the extra stage unchanged.
- Undefined: latency 1 as above.

Test Plan:
- Clear, ADDR_WIDTH=4:
  - Release rst_n, hold all requests low -> init_done rises exactly 16 cycles later.
  - Then read all 16 addresses -> every rd_data = 0x00.
- Write then read:
  - Write 0xA5 to addr 3, then read addr 3 next cycle -> rd_valid=1 with rd_data=0xA5 one cycle after the read request (two cycles with OUTREG_EN).
- Collision:
  - mem[7]=0x11. Same cycle: wr_req to addr 7 with 0x3C and rd_req to addr 7 -> rd_data=0x3C, rd_valid=1.
- Requests during clear:
  - wr_req to addr 2 with 0xFF and rd_req during CLEAR -> rd_valid stays 0.
  - After init_done, read addr 2 -> 0x00.
- Reset mid-clear:
  - Assert rst_n=0 for 1 cycle at clear cycle 8 -> init_done low, then rises 16 cycles after release.
- Streaming:
  - Fill addrs 0..15 with value=addr, read 0..15 back-to-back -> rd_valid high for 16 consecutive cycles, rd_data = 0,1,...,15.
